// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared types for the LED input pipeline
package pipeline_types;

  localparam int BITS_PER_PIXEL_DEFAULT = 24;

  typedef struct packed {
    logic bit_valid;
    logic bit_value;
    logic latch;
    logic sym_error;
  } shift_reg_input_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } pixel_sr_state_t;

endpackage

// File: rtl/pixel_shift_reg_if.sv
// rtl/pixel_shift_reg_if.sv - decoder-to-shift-register symbol bundle
interface pixel_shift_reg_if
  import pipeline_types::*;
  ;
  shift_reg_input_t shift_reg;

  modport master (output shift_reg);
  modport slave  (input  shift_reg);
endinterface

// File: rtl/pixel_shift_reg.sv
// rtl/pixel_shift_reg.sv - captures the first pixel of each frame and commits it on a clean latch
module pixel_shift_reg
  import pipeline_types::*;
#(
  parameter int BITS_PER_PIXEL = BITS_PER_PIXEL_DEFAULT,
  parameter int PASSTHRU_W     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  shift_reg_input_t          i_shift_reg,
  output logic [BITS_PER_PIXEL-1:0] o_grb,
  output logic                      o_latch,
  output logic                      o_frame_error,
  output logic [PASSTHRU_W-1:0]     o_passthru_cnt,
  output logic                      o_busy
);

  localparam int CNT_W = $clog2(BITS_PER_PIXEL + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BITS_PER_PIXEL);

  pixel_sr_state_t           r_state;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [PASSTHRU_W-1:0]     r_acc;

  pixel_sr_state_t           w_state_nxt;
  logic [CNT_W-1:0]          w_bit_cnt_nxt;
  logic [CNT_W-1:0]          w_bit_cnt_inc;
  logic [BITS_PER_PIXEL-1:0] w_shift_nxt;
  logic [BITS_PER_PIXEL-1:0] w_shift_in;
  logic [PASSTHRU_W-1:0]     w_acc_nxt;
  logic                      w_commit;
  logic                      w_frame_err;

  // Shift by operator rather than slice so a one-bit pixel still elaborates.
  assign w_shift_in    = (r_shift << 1) | BITS_PER_PIXEL'(i_shift_reg.bit_value);
  assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_acc_nxt     = r_acc;
    w_commit      = 1'b0;
    w_frame_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_shift_reg.latch) begin
          w_state_nxt = IDLE;
        end else if (i_shift_reg.sym_error) begin
          w_state_nxt = DISCARD;
        end else if (i_shift_reg.bit_valid) begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = CNT_W'(1);
          w_state_nxt   = (FULL_CNT == CNT_W'(1)) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        if (i_shift_reg.latch) begin
          w_frame_err   = 1'b1;
          w_bit_cnt_nxt = '0;
          w_acc_nxt     = '0;
          w_state_nxt   = IDLE;
        end else if (i_shift_reg.sym_error) begin
          w_state_nxt = DISCARD;
        end else if (i_shift_reg.bit_valid) begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = w_bit_cnt_inc;
          if (w_bit_cnt_inc == FULL_CNT) begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_shift_reg.latch) begin
          w_commit      = 1'b1;
          w_bit_cnt_nxt = '0;
          w_acc_nxt     = '0;
          w_state_nxt   = IDLE;
        end else if (i_shift_reg.sym_error) begin
          w_state_nxt = DISCARD;
        end else if (i_shift_reg.bit_valid && (r_acc != '1)) begin
          w_acc_nxt = r_acc + PASSTHRU_W'(1);
        end
      end
      DISCARD: begin
        if (i_shift_reg.latch) begin
          w_frame_err   = 1'b1;
          w_bit_cnt_nxt = '0;
          w_acc_nxt     = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_acc          <= '0;
      o_grb          <= '0;
      o_latch        <= 1'b0;
      o_frame_error  <= 1'b0;
      o_passthru_cnt <= '0;
      o_busy         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_acc         <= w_acc_nxt;
      o_latch       <= w_commit;
      o_frame_error <= w_frame_err;
      o_busy        <= (w_state_nxt != IDLE);
      if (w_commit) begin
        o_grb          <= r_shift;
        o_passthru_cnt <= r_acc;
      end
    end
  end

endmodule

// File: doc/pixel_shift_reg.md
# pixel_shift_reg

Final stage of the LED input pipeline, directly downstream of the two-stage pulse decoder. Consumes one decoded symbol per event from the decoder (data bit, latch/reset code, or symbol error) and assembles the first BITS_PER_PIXEL bits of each frame into a GRB word. Commits that word to a display register only on a clean latch. Bits beyond the first pixel are counted as pass-through traffic and are otherwise ignored.

## Interface
Parameters:
- BITS_PER_PIXEL, 24: bits captured per frame, MSB first, GRB order.
- PASSTHRU_W, 16: width of the saturating pass-through bit counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_shift_reg  in  pipeline_types::shift_reg_input_t  decoder output struct. Fields:
  - bit_valid: one-cycle strobe.
  - bit_value: decoded bit, qualified by bit_valid.
  - latch: one-cycle strobe for a reset code.
  - sym_error: one-cycle strobe for a malformed symbol.
- o_grb  out  BITS_PER_PIXEL  display register: last committed pixel.
- o_latch  out  1  one-cycle pulse when o_grb is updated.
- o_frame_error  out  1  one-cycle pulse when a frame is discarded.
- o_passthru_cnt  out  PASSTHRU_W  bits received after the pixel was full, in the last committed frame.
- o_busy  out  1  high when the state is not IDLE.

## Operation
- Sync, active-high reset returns the block to IDLE with every output zero:
  - o_grb, o_latch, o_frame_error and o_passthru_cnt are 0.
  - o_busy is 0.
  - bit_cnt, the shift register and the pass-through accumulator are 0.
- States: IDLE, SHIFT, HOLD, DISCARD. State is encoded as an enum from the package.
- Shifting on a bit: shift_q <= {shift_q[BITS_PER_PIXEL-2:0], bit_value} and bit_cnt increments. bit_cnt is $clog2(BITS_PER_PIXEL+1) bits wide.
- IDLE:
  - bit_valid: shift the bit, set bit_cnt=1, go to SHIFT. If BITS_PER_PIXEL==1, go to HOLD instead.
  - latch: no effect; no pulse on any output.
  - sym_error: go to DISCARD.
- SHIFT:
  - bit_valid: shift the bit. When bit_cnt reaches BITS_PER_PIXEL, go to HOLD.
  - latch with a partial pixel: pulse o_frame_error, clear the counters, go to IDLE. o_grb is unchanged.
  - sym_error: go to DISCARD.
- HOLD:
  - bit_valid: do not shift. The pass-through accumulator increments and saturates at 2^PASSTHRU_W-1.
  - latch: o_grb <= shift_q, o_passthru_cnt <= accumulator, pulse o_latch, clear the counters, go to IDLE.
  - sym_error: go to DISCARD. The captured pixel is lost.
- DISCARD:
  - Bits and errors are ignored.
  - latch: pulse o_frame_error, clear the counters, go to IDLE. o_grb is unchanged.
- Simultaneous strobes, priority order latch > sym_error > bit_valid:
  - latch with bit_valid: the latch is processed and the bit is dropped.
  - sym_error with bit_valid: go to DISCARD and drop the bit.
- i_reset has priority over every input. A reset in the middle of a frame drops the partial pixel and does not produce an o_frame_error pulse.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency:
  - An input strobe in cycle N updates the state and counters at the edge ending cycle N; the result is visible in cycle N+1.
  - A latch in cycle N: o_grb, o_passthru_cnt and o_latch all change together in cycle N+1.
  - o_latch and o_frame_error are high for exactly one cycle and are never high together.
- Back-to-back strobes in consecutive cycles are accepted. No backpressure; the block is always ready.
- o_busy goes high in the cycle after the first accepted bit_valid or sym_error. It goes low in the cycle after the latch.

## Structure
- In pipeline_types:
  - shift_reg_input_t, extended with the sym_error field.
  - The pixel_sr_state_t enum.
  - A BITS_PER_PIXEL_DEFAULT=24 constant.
- Single module with no sub-modules. Use one sequential process and one next-state combinational process.
- The decoder wrapper's o_shift_reg connects directly to i_shift_reg.

## Test plan
- Clean frame: 24 bits of 0xA5C3F0 MSB first, then latch.
  - Response: o_grb=0xA5C3F0 with o_latch pulsed once, one cycle after the latch.
  - o_passthru_cnt=0 and o_frame_error never pulses.
- Cascade traffic: 72 bits (pixel 0x123456 followed by 48 more), then latch.
  - Response: o_grb=0x123456 and o_passthru_cnt=48.
- Short frame: 10 bits, then latch.
  - Response: o_frame_error pulses once, o_grb keeps its previous value, o_latch stays 0.
  - Then 24 bits of 0x00FF00 and a latch give o_grb=0x00FF00.
- Symbol error: sym_error after bit 30, followed by more bits, then latch.
  - Response: o_frame_error pulses, o_grb is unchanged, the block returns to IDLE.
  - Also drive bit_valid and latch in the same cycle: the latch wins.
- Reset mid-frame: assert i_reset after bit 12.
  - Response: the next cycle shows all outputs 0, no o_frame_error pulse, o_busy=0.
  - A following full frame commits correctly.
- Saturation: 2^16+100 bits in HOLD with PASSTHRU_W=16, then latch.
  - Response: o_passthru_cnt=16'hFFFF.
